// File: rtl/multicast_bus_tx_if.sv
// Bundles the upstream word stream and the caster-side bus of multicast_bus_tx.
// master is the transmitter's view, slave is the view of the surrounding logic.
interface multicast_bus_tx_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int TW         = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [TW-1:0]         in_tag;
    logic [DATA_WIDTH-1:0] bus_data;
    logic [TW-1:0]         bus_tag;
    logic [NUM_COL-1:0]    caster_en;
    logic [NUM_COL-1:0]    caster_ready;

    modport master (
        input  in_valid, in_data, in_tag, caster_ready,
        output in_ready, bus_data, bus_tag, caster_en
    );

    modport slave (
        output in_valid, in_data, in_tag, caster_ready,
        input  in_ready, bus_data, bus_tag, caster_en
    );
endinterface

// File: rtl/multicast_bus_tx.sv
// Multicast bus transmitter: input FIFO, tag-to-column match, per-column enables held until accepted.
// Optional drop counter enabled by defining MCAST_TX_DROP_CNT_EN.
module multicast_bus_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TW         = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    multicast_bus_tx_if.master    bus,
    input  logic [NUM_COL*TW-1:0] id_cfg,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic {IDLE, SEND} state_t;

    // Small register FIFO; the head is read combinationally so its match resolves in the pop cycle.
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [TW-1:0]         tag_mem  [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_reg, rd_ptr_reg;
    logic                  fifo_empty, fifo_full, push, pop;
    logic [DATA_WIDTH-1:0] head_data;
    logic [TW-1:0]         head_tag;
    logic [NUM_COL-1:0]    match;

    state_t                state_reg, state_next;
    logic [NUM_COL-1:0]    pending_reg, pending_next;
    logic [DATA_WIDTH-1:0] bus_data_reg, bus_data_next;
    logic [TW-1:0]         bus_tag_reg, bus_tag_next;
    logic                  done;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push       = bus.in_valid && !fifo_full;
    assign head_data  = data_mem[rd_ptr_reg[AW-1:0]];
    assign head_tag   = tag_mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg[AW-1:0]] <= bus.in_data;
            tag_mem[wr_ptr_reg[AW-1:0]]  <= bus.in_tag;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_match
            assign match[gi] = (id_cfg[gi*TW +: TW] == head_tag);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            bus_data_reg <= '0;
            bus_tag_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            bus_data_reg <= bus_data_next;
            bus_tag_reg  <= bus_tag_next;
        end
    end

    // A column that is ready in the current cycle counts as accepted, so done looks through ready.
    assign done = ((pending_reg & ~bus.caster_ready) == '0);

    always_comb begin
        state_next    = state_reg;
        pending_next  = pending_reg;
        bus_data_next = bus_data_reg;
        bus_tag_next  = bus_tag_reg;
        pop           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (match != '0) begin
                        state_next    = SEND;
                        pending_next  = match;
                        bus_data_next = head_data;
                        bus_tag_next  = head_tag;
                    end
                end
            end
            SEND: begin
                pending_next = pending_reg & ~bus.caster_ready;
                if (done) begin
                    state_next = IDLE;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (match != '0) begin
                            state_next    = SEND;
                            pending_next  = match;
                            bus_data_next = head_data;
                            bus_tag_next  = head_tag;
                        end
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.bus_data  = bus_data_reg;
    assign bus.bus_tag   = bus_tag_reg;
    assign bus.caster_en = pending_reg;
    assign busy          = !fifo_empty || (state_reg == SEND);

`ifdef MCAST_TX_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_cnt_reg;

    assign drop = pop && (match == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`else
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_multicast_bus_tx.sv
// Randomized and directed bench for multicast_bus_tx against a queue-based word model.
// Honours MCAST_TX_DROP_CNT_EN for the expected drop count.
module tb_multicast_bus_tx;
    localparam int DW    = 16;
    localparam int NC    = 4;
    localparam int DEPTH = 4;
    localparam int TW    = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NC*TW-1:0] id_cfg;
    logic             busy;
    logic [7:0]       drop_cnt;

    always #5 clk = ~clk;

    multicast_bus_tx_if #(.DATA_WIDTH(DW), .NUM_COL(NC)) bus_if ();

    multicast_bus_tx #(.DATA_WIDTH(DW), .NUM_COL(NC), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .id_cfg   (id_cfg),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    // Model state: words accepted but not yet taken, columns still owed for the current word.
    word_t         mq[$];
    logic [NC-1:0] owed;
    logic [DW-1:0] cur_data;
    logic [TW-1:0] cur_tag;
    int            drops;
    int            total = 0;
    int            bad   = 0;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] mask_of(input logic [TW-1:0] t);
        logic [NC-1:0] m;
        for (int c = 0; c < NC; c++) m[c] = (id_cfg[c*TW +: TW] == t);
        return m;
    endfunction

    function automatic logic [7:0] exp_drop();
`ifdef MCAST_TX_DROP_CNT_EN
        return (drops > 255) ? 8'd255 : 8'(drops);
`else
        return 8'd0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        owed     = '0;
        cur_data = '0;
        cur_tag  = '0;
        drops    = 0;
    endtask

    task automatic check_outputs();
        check_val("caster_en", 32'(bus_if.caster_en), 32'(owed));
        check_val("bus_data",  32'(bus_if.bus_data),  32'(cur_data));
        check_val("bus_tag",   32'(bus_if.bus_tag),   32'(cur_tag));
        check_val("in_ready",  32'(bus_if.in_ready),  32'(mq.size() < DEPTH));
        check_val("busy",      32'(busy),             32'((mq.size() != 0) || (owed != '0)));
        check_val("drop_cnt",  32'(drop_cnt),         32'(exp_drop()));
    endtask

    // One cycle: check outputs, drive inputs, advance the model, wait for the next falling edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [TW-1:0] t,
                        input logic [NC-1:0] r, output logic took);
        logic [NC-1:0] left;
        logic [NC-1:0] m;
        word_t         w;
        check_outputs();
        bus_if.in_valid     = v;
        bus_if.in_data      = d;
        bus_if.in_tag       = t;
        bus_if.caster_ready = r;
        took = v && (mq.size() < DEPTH);
        left = owed & ~r;
        if (left == '0) begin
            if (mq.size() > 0) begin
                w = mq.pop_front();
                m = mask_of(w.tag);
                if (m != '0) begin
                    owed     = m;
                    cur_data = w.data;
                    cur_tag  = w.tag;
                    $display("load tag=%0d data=%h mask=%b", w.tag, w.data, m);
                end else begin
                    owed = '0;
                    drops++;
                    $display("drop tag=%0d data=%h", w.tag, w.data);
                end
            end else begin
                owed = '0;
            end
        end else begin
            owed = left;
        end
        if (took) begin
            w.data = d;
            w.tag  = t;
            mq.push_back(w);
        end
        @(negedge clk);
    endtask

    initial begin
        logic          tk;
        logic [NC-1:0] r;
        logic [31:0]   rv;
        int            n;

        bus_if.in_valid     = 1'b0;
        bus_if.in_data      = '0;
        bus_if.in_tag       = '0;
        bus_if.caster_ready = '0;
        id_cfg = {2'd3, 2'd2, 2'd1, 2'd0};
        model_reset();

        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        check_outputs();
        rst = 1'b0;

        // Unicast to column 2
        step(1'b1, 16'h1234, 2'd2, '1, tk);
        repeat (4) step(1'b0, '0, '0, '1, tk);

        // Multicast to columns 0,1,3 with staggered ready
        id_cfg = {2'd1, 2'd0, 2'd1, 2'd1};
        step(1'b1, 16'hBEEF, 2'd1, '0, tk);
        step(1'b0, '0, '0, '0, tk);
        for (int k = 0; k < 8; k++) begin
            r = {(k == 5), 1'b0, (k == 3), (k == 0)};
            step(1'b0, '0, '0, r, tk);
        end

        // Back-to-back unicast to every column
        id_cfg = {2'd3, 2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 4; i++) step(1'b1, 16'hA000 + 16'(i), 2'(i), '1, tk);
        repeat (3) step(1'b0, '0, '0, '1, tk);

        // Fill the FIFO under backpressure, then release
        n = 0;
        for (int i = 0; i < 24 && n < 6; i++) begin
            r = (i >= 10) ? '1 : '0;
            step(1'b1, 16'hC000 + 16'(n), 2'(n), r, tk);
            if (tk) n++;
            if (i == 7) check_val("full_in_ready", 32'(bus_if.in_ready), 32'd0);
        end
        repeat (8) step(1'b0, '0, '0, '1, tk);

        // Unmatched word is dropped, matched word broadcasts
        id_cfg = '0;
        step(1'b1, 16'h0D0D, 2'd3, '1, tk);
        step(1'b1, 16'h0F0F, 2'd0, '1, tk);
        repeat (4) step(1'b0, '0, '0, '1, tk);
`ifdef MCAST_TX_DROP_CNT_EN
        check_val("drop_one", 32'(drop_cnt), 32'd1);
`else
        check_val("drop_one", 32'(drop_cnt), 32'd0);
`endif

        // Reset while sending with two words queued
        id_cfg = {2'd3, 2'd2, 2'd1, 2'd0};
        step(1'b1, 16'h1111, 2'd2, '0, tk);
        step(1'b1, 16'h2222, 2'd0, '0, tk);
        step(1'b1, 16'h3333, 2'd1, '0, tk);
        check_val("pre_rst_en", 32'(bus_if.caster_en), 32'h4);
        check_val("pre_rst_q", 32'(mq.size()), 32'd2);
        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        #1;
        check_val("rst_en",    32'(bus_if.caster_en), 32'd0);
        check_val("rst_busy",  32'(busy),             32'd0);
        check_val("rst_ready", 32'(bus_if.in_ready),  32'd1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) step(1'b0, '0, '0, '1, tk);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ((owed == '0) && (mq.size() == 0) && ($urandom_range(0, 7) == 0)) begin
                rv = $urandom;
                id_cfg = rv[NC*TW-1:0];
            end
            rv = $urandom;
            step(($urandom_range(0, 9) < 6), rv[DW-1:0], rv[DW+TW-1:DW], rv[31:32-NC], tk);
        end
        repeat (12) step(1'b0, '0, '0, '1, tk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
